// File: rtl/ma_unit.sv
// ma_unit: synchronizes async level A and emits rising (re) / falling (wa) edge pulses plus a
// retriggerable activity window (ka). Define MA_UNIT_FILTER_EN to add a stability filter on the input.
module ma_unit #(
   parameter int SYNC_STAGES = 2,   // 2..4
   parameter int FILTER_LEN  = 3,   // 1..15, filter build only
   parameter int HOLD        = 8    // 1..255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic A,
   output logic re,
   output logic wa,
   output logic ka
);
   localparam int CNT_W = $clog2(HOLD + 1);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   a_s;
   logic                   a_f;
   logic                   prev_reg;
   logic [CNT_W-1:0]       cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], A};
      end
   end

   assign a_s = sync_reg[SYNC_STAGES-1];

`ifdef MA_UNIT_FILTER_EN
   localparam int FCNT_W = $clog2(FILTER_LEN + 1);
   localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_LEN - 1);

   logic [FCNT_W-1:0] fcnt_reg;
   logic              a_f_reg;

   // Any return of a_s to the accepted level restarts the stability count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fcnt_reg <= '0;
         a_f_reg  <= 1'b0;
      end else if (a_s == a_f_reg) begin
         fcnt_reg <= '0;
      end else if (fcnt_reg == FCNT_LAST) begin
         fcnt_reg <= '0;
         a_f_reg  <= a_s;
      end else begin
         fcnt_reg <= fcnt_reg + FCNT_W'(1);
      end
   end

   assign a_f = a_f_reg;
`else
   logic [7:0] unused_filter_len;

   assign unused_filter_len = 8'(FILTER_LEN);
   assign a_f = a_s;
`endif

   // prev clears on reset, so a level already high at release reads as a rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_reg <= 1'b0;
         re       <= 1'b0;
         wa       <= 1'b0;
      end else begin
         prev_reg <= a_f;
         re       <= a_f & ~prev_reg;
         wa       <= ~a_f & prev_reg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (re | wa) begin
         cnt_reg <= CNT_W'(HOLD);
      end else if (cnt_reg != '0) begin
         cnt_reg <= cnt_reg - CNT_W'(1);
      end
   end

   assign ka = (cnt_reg != '0);

endmodule

// File: tb/tb_ma_unit.sv
// Testbench for ma_unit: directed stimulus pushes expected re/wa pulses into a scoreboard queue,
// a negedge monitor pops and compares them and checks the ka window every cycle.
module tb_ma_unit;
   localparam int SYNC_STAGES = 2;
   localparam int FILTER_LEN  = 3;
   localparam int HOLD        = 8;
`ifdef MA_UNIT_FILTER_EN
   localparam int LAT = SYNC_STAGES + 1 + FILTER_LEN;
   localparam int PW  = 5;
`else
   localparam int LAT = SYNC_STAGES + 1;
   localparam int PW  = 1;
`endif
   localparam int K_RE = 1;
   localparam int K_WA = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic A     = 1'b0;
   logic re;
   logic wa;
   logic ka;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int kind;
      int cyc;
   } exp_t;

   exp_t exp_q[$];
   int   edge_q[$];

   ma_unit #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN (FILTER_LEN),
      .HOLD       (HOLD)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .A    (A),
      .re   (re),
      .wa   (wa),
      .ka   (ka)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, exp);
      end
   endtask

   task automatic expect_ev(input int kind);
      exp_t e;
      e.kind = kind;
      e.cyc  = cyc + LAT;
      exp_q.push_back(e);
      edge_q.push_back(e.cyc);
   endtask

   // Drive A just after a rising edge; kind != 0 pushes the pulse this change must produce.
   task automatic set_a(input logic v, input int kind);
      @(posedge clk);
      #1;
      A = v;
      if (kind != 0) expect_ev(kind);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic count_ka(input int n, output int hi);
      hi = 0;
      repeat (n) begin
         @(negedge clk);
         hi += int'(ka);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin : mon
      exp_t e;
      int   exp_ka;
      int   kind;
      exp_ka = 0;
      if (rst_n) begin
         foreach (edge_q[i]) begin
            if (edge_q[i] < cyc && cyc <= edge_q[i] + HOLD) exp_ka = 1;
         end
      end
      check("ka_window", int'(ka), exp_ka);
      check("re_wa_exclusive", int'(re & wa), 0);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         check("missed_pulse_cycle", cyc, exp_q[0].cyc);
         exp_q.delete(0);
      end
      kind = re ? K_RE : (wa ? K_WA : 0);
      if (kind != 0) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", kind, 0);
         end else begin
            e = exp_q.pop_front();
            check("pulse_kind", kind, e.kind);
            check("pulse_cycle", cyc, e.cyc);
            $display("cycle %0d: %s pulse (expected %s at %0d) ka=%0b", cyc,
                     (kind == K_RE) ? "re" : "wa", (e.kind == K_RE) ? "re" : "wa", e.cyc, ka);
         end
      end
   end

   initial begin
      int h;

      // Reset held with A toggling: all outputs stay low
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         A = ~A;
         @(negedge clk);
         check("reset_re", int'(re), 0);
         check("reset_wa", int'(wa), 0);
         check("reset_ka", int'(ka), 0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      wait_cyc(12);

`ifndef MA_UNIT_FILTER_EN
      // Single one-cycle pulse: re, wa one cycle later, ka retriggered by wa
      set_a(1'b1, K_RE);
      set_a(1'b0, K_WA);
      count_ka(20, h);
      check("single_ka_len", h, 9);

      // Back-to-back pulses: re,wa,re,wa in consecutive cycles
      set_a(1'b1, K_RE);
      set_a(1'b0, K_WA);
      set_a(1'b1, K_RE);
      set_a(1'b0, K_WA);
      count_ka(20, h);
      check("burst_ka_len", h, 11);
`else
      // Two-cycle glitch is rejected by the filter
      set_a(1'b1, 0);
      set_a(1'b1, 0);
      set_a(1'b0, 0);
      count_ka(20, h);
      check("glitch_ka_len", h, 0);

      // Five-cycle pulse passes: re and wa both delayed by the filter
      set_a(1'b1, K_RE);
      repeat (4) set_a(1'b1, 0);
      set_a(1'b0, K_WA);
      count_ka(25, h);
      check("pulse5_ka_len", h, 13);
`endif

      // Long pulse: two separate HOLD windows
      set_a(1'b1, K_RE);
      count_ka(20, h);
      check("long_rise_ka_len", h, HOLD);
      set_a(1'b0, K_WA);
      count_ka(20, h);
      check("long_fall_ka_len", h, HOLD);

      // Reset asserted mid-window drops ka without a clock edge
      set_a(1'b1, K_RE);
      repeat (PW - 1) set_a(1'b1, 0);
      set_a(1'b0, K_WA);
      wait_cyc(LAT + 2);
      check("ka_before_reset", int'(ka), 1);
      #2;
      rst_n = 1'b0;
      edge_q.delete();
      #1;
      check("ka_async_clear", int'(ka), 0);
      check("re_async_clear", int'(re), 0);
      check("wa_async_clear", int'(wa), 0);

      // A held high through release is seen as a rising edge, with a full window
      A = 1'b1;
      wait_cyc(3);
      rst_n = 1'b1;
      expect_ev(K_RE);
      count_ka(20, h);
      check("post_reset_ka_len", h, HOLD);
      set_a(1'b0, K_WA);
      wait_cyc(LAT + HOLD + 4);

      check("pending_expected", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
